// File: rtl/adder_operand_gather_if.sv
// adder_operand_gather_if
//   Bundles the word stream feeding the gatherer and the operand-triple
//   stream it presents to the 3-input adder.
//   Input stream : in_valid, in_ready, in_data[WIDTH], in_last
//   Output stream: out_valid, out_ready, out0/out1/out2[WIDTH],
//                  out_count[2] (real operands, 1..3), out_last
//   master: producer of words / consumer of triples (testbench, upstream)
//   slave : the gatherer itself
interface adder_operand_gather_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [1:0]       out_count;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out0, out1, out2, out_count, out_last
  );
endinterface

// File: rtl/adder_operand_gather.sv
// adder_operand_gather
//   Gathers every three accepted words into an operand triple for the
//   3-input adder. A group closed early by in_last is zero-padded so the
//   downstream sum only sees real operands. One word per cycle when the
//   consumer keeps out_ready high.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : adder_operand_gather_if.slave (input word stream, triple outputs)
// All outputs are registered except bus.in_ready, which is combinational
// from state and out_ready.
module adder_operand_gather #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_operand_gather_if.slave bus
);

  typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_idx;
  logic [2:0][WIDTH-1:0] r_slot;
  logic [1:0]            r_count;
  logic                  r_last;

  logic       w_in_ready;
  logic       w_in_fire;
  logic       w_close;
  logic [1:0] w_wr_idx;

  // A word accepted in HOLD is only possible on the cycle the held triple
  // leaves, and it always starts the next group at slot 0.
  assign w_in_fire = bus.in_valid & w_in_ready;
  assign w_wr_idx  = (r_state == S_HOLD) ? 2'd0 : r_idx;
  assign w_close   = w_in_fire & ((w_wr_idx == 2'd2) | bus.in_last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_close)
      w_next = S_HOLD;
    else if (w_in_fire)
      w_next = S_FILL;
    else if ((r_state == S_HOLD) && bus.out_ready)
      w_next = S_FILL;
  end

  // Output logic: the only combinational output
  always_comb begin
    w_in_ready = (r_state == S_FILL) | bus.out_ready;
  end

  // Slot / metadata datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_slot  <= '0;
      r_count <= 2'd0;
      r_last  <= 1'b0;
    end else if (w_in_fire) begin
      r_slot[w_wr_idx] <= bus.in_data;
      if (w_close) begin
        // Pad unused slots so out0+out1+out2 equals the real-operand sum.
        if (w_wr_idx == 2'd0) r_slot[1] <= '0;
        if (w_wr_idx != 2'd2) r_slot[2] <= '0;
        r_count <= w_wr_idx + 2'd1;
        r_last  <= bus.in_last;
        r_idx   <= 2'd0;
      end else begin
        r_idx   <= w_wr_idx + 2'd1;
      end
    end else if ((r_state == S_HOLD) && bus.out_ready) begin
      r_idx <= 2'd0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.out0      = r_slot[0];
  assign bus.out1      = r_slot[1];
  assign bus.out2      = r_slot[2];
  assign bus.out_count = r_count;
  assign bus.out_last  = r_last;

endmodule
